// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - operator-driven instruction memory loader
//
// Captures switch values into consecutive instruction-memory words, one per
// load-button press, tracks the fill level and hands off to execution mode on
// the run button.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   load_btn  in   debounced load button (level)
//   run_btn   in   debounced run button (level)
//   sw        in   [DATA_W-1:0] instruction value from switches
//   im_we     out  IM write strobe, one cycle per stored instruction
//   im_waddr  out  [ADDR_W-1:0] IM write address
//   im_wdata  out  [DATA_W-1:0] IM write data (captured switch value)
//   count     out  [ADDR_W:0] instructions stored, 0..DEPTH
//   full      out  count == DEPTH
//   overflow  out  sticky: load attempted while full
//   run_mode  out  loading finished, program executing

module instruction_loader #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_btn,
  input  logic              run_btn,
  input  logic [DATA_W-1:0] sw,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [DATA_W-1:0] im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  output logic              run_mode
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  // count value at which the store in progress fills the memory
  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(DEPTH - 1);

  state_t            state, next_state;
  logic              load_prev, run_prev;
  logic              load_rise, run_rise;
  logic [ADDR_W-1:0] wr_ptr;
  logic              im_we_r;
  logic              capture;
  logic              set_ovf;

  assign load_rise = load_btn & ~load_prev;
  assign run_rise  = run_btn  & ~run_prev;

  // The strobe is registered, but a reset landing on the WRITE cycle must
  // kill that write, so it is masked by rst on the way out.
  assign im_we = im_we_r & ~rst;

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    set_ovf    = 1'b0;
    case (state)
      S_LOAD: begin
        // run wins over a simultaneous load; run with nothing stored is ignored
        if (run_rise && (count != '0)) begin
          next_state = S_RUN;
        end else if (load_rise) begin
          next_state = S_WRITE;
          capture    = 1'b1;
        end
      end
      S_WRITE: begin
        // edges seen in this cycle are consumed by the _prev registers and lost
        next_state = (count == LAST_COUNT) ? S_FULL : S_LOAD;
      end
      S_FULL: begin
        if (run_rise) begin
          next_state = S_RUN;
        end else if (load_rise) begin
          set_ovf = 1'b1;
        end
      end
      S_RUN: begin
        next_state = S_RUN;
      end
      default: begin
        next_state = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD;
      // held high through reset so a button already down gives no edge
      load_prev <= 1'b1;
      run_prev  <= 1'b1;
      wr_ptr    <= '0;
      count     <= '0;
      im_we_r   <= 1'b0;
      im_waddr  <= '0;
      im_wdata  <= '0;
      full      <= 1'b0;
      overflow  <= 1'b0;
      run_mode  <= 1'b0;
    end else begin
      state     <= next_state;
      load_prev <= load_btn;
      run_prev  <= run_btn;
      im_we_r   <= (next_state == S_WRITE);
      run_mode  <= (next_state == S_RUN);
      if (capture) begin
        im_wdata <= sw;
        im_waddr <= wr_ptr;
      end
      if (state == S_WRITE) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
        full   <= (count == LAST_COUNT);
      end
      if (set_ovf) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
